reshape_split: RTL and testbench
================================

Name: reshape_split

Overview:
- Inverse of the channel-flattening stage: accepts one flattened serial stream of 3 x MAP_SIZE words in channel order (ch1 words, then ch2, then ch3).
- Re-emits the stream as three parallel, word-aligned channel streams, each MAP_SIZE words long (default 5x5 = 25).
- Sits between the flattened-vector domain (FC/classifier data path or external loader) and per-channel 5x5 processing logic.
- Buffers ch1 and ch2 internally and releases all three channels in lockstep while ch3 arrives.

Parameters:
- DATA_WIDTH, 32, width of every data word.
- MAP_SIZE, 25, words per channel (5x5 feature map).
- CNT_WIDTH, 5, counter width; must satisfy 2^CNT_WIDTH > MAP_SIZE.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- predict_end  in  1  synchronous clear; aborts the current frame.
- data_in  in  DATA_WIDTH  flattened input word.
- data_in_valid  in  1  data_in qualifier; gaps allowed at any point.
- data_out_1  out  DATA_WIDTH  channel 1 word.
- data_out_2  out  DATA_WIDTH  channel 2 word.
- data_out_3  out  DATA_WIDTH  channel 3 word.
- data_out_valid  out  1  all three outputs valid together.
- frame_done  out  1  one-cycle pulse coincident with the last (MAP_SIZE-th) output triple.

Behaviour:
- Reset: state=S_CH1, cnt=0, data_out_1/2/3=0, data_out_valid=0, frame_done=0. Buffer contents are don't-care.
- FSM states: S_CH1, S_CH2, S_CH3. cnt counts accepted beats within the current state, range 0..MAP_SIZE-1.
- S_CH1: each valid beat writes buf1[cnt] and increments cnt. On the beat with cnt==MAP_SIZE-1, set cnt=0 and go to S_CH2.
- S_CH2: same behaviour, writing buf2. The last beat goes to S_CH3.
- S_CH3: each valid beat registers data_out_1=buf1[cnt], data_out_2=buf2[cnt], data_out_3=data_in, and sets data_out_valid=1 on the next edge.
  - Latency: 1 cycle from the ch3 beat to the output triple.
  - On the beat with cnt==MAP_SIZE-1, also pulse frame_done with that triple, set cnt=0, and return to S_CH1.
- Cycles with data_in_valid=0: state and cnt hold, data_out_valid=0, frame_done=0. Data outputs hold their last value.
- Back-to-back frames: a ch1 beat of the next frame may arrive in the cycle right after the last ch3 beat; no bubble is required.
- predict_end=1 (any state):
  - Next edge: state=S_CH1, cnt=0, data_out_valid=0, frame_done=0.
  - A data_in_valid beat in the same cycle is dropped; clear has priority.
  - Partially filled buffers are abandoned; no output is produced for the aborted frame.
- rst_n deassertion mid-frame: identical to reset; the partial frame is lost.
- Buffer reads are combinational (register array) so ch1/ch2/ch3 of the same index align without extra delay.
- No backpressure: downstream must accept one triple per cycle.
- Words pass through unmodified; no arithmetic on data.

Decomposition:
- Shared package: state encoding constants (S_CH1=2'd0, S_CH2=2'd1, S_CH3=2'd2) and the default MAP_SIZE/DATA_WIDTH values, shared with the forward flatten stage.
- One sub-module: channel_buffer.
  - MAP_SIZE x DATA_WIDTH register array.
  - Synchronous write port: we, waddr, wdata.
  - Asynchronous read port: raddr, rdata.
  - Instantiated twice: buf1 and buf2.
- Top level holds the FSM, cnt, and output registers.

Test Plan:
- Contiguous frame: drive data_in = 1..75, one per cycle, from cycle 0.
  - Triples (1,26,51) through (25,50,75) appear at cycles 51..75 with data_out_valid=1.
  - frame_done=1 only at cycle 75; no valid before cycle 51.
- Gapped input: same values 1..75 with valid toggling 1,0,1,0.
  - Identical 25 triples, each one cycle after its ch3 beat.
  - data_out_valid=0 in gap cycles.
- Back-to-back frames: values 1..75 then 101..175 with no gap.
  - Second frame's triples run (101,126,151)..(125,150,175).
  - frame_done pulses exactly twice.
- predict_end mid-frame: assert at beat 40 (during ch2), then send 1..75.
  - No output from the aborted frame.
  - Clean triples (1,26,51)..(25,50,75) follow.
- predict_end coincident with a valid beat in S_CH3: that beat is dropped.
  - data_out_valid=0 on the next cycle; state returns to S_CH1, cnt=0.
- Async reset mid-frame: pull rst_n low at beat 60.
  - All outputs go to 0 immediately.
  - After release, a full frame 1..75 produces correct triples.

Source files
------------

// File: rtl/reshape_split_pkg.sv
// Shared definitions for the flatten / reshape_split stage pair.
package reshape_split_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_MAP_SIZE   = 25;
  localparam int unsigned DEF_CNT_WIDTH  = 5;

  typedef enum logic [1:0] {
    S_CH1 = 2'd0,
    S_CH2 = 2'd1,
    S_CH3 = 2'd2
  } state_e;

endpackage

// File: rtl/reshape_split_channel_buffer.sv
// One channel's worth of words: synchronous write, combinational read so a
// stored word lines up with the live ch3 word of the same index.
module reshape_split_channel_buffer
  import reshape_split_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MAP_SIZE   = DEF_MAP_SIZE,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [CNT_WIDTH-1:0]  waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [CNT_WIDTH-1:0]  raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_c
);

  logic [DATA_WIDTH-1:0] mem_q [MAP_SIZE];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_c = mem_q[raddr_i];

endmodule

// File: rtl/reshape_split.sv
// Splits a flattened ch1|ch2|ch3 stream into three word-aligned channel
// streams; ch1/ch2 are buffered and released in lockstep with arriving ch3.
module reshape_split
  import reshape_split_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MAP_SIZE   = DEF_MAP_SIZE,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  predict_end,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic [DATA_WIDTH-1:0] data_out_1,
  output logic [DATA_WIDTH-1:0] data_out_2,
  output logic [DATA_WIDTH-1:0] data_out_3,
  output logic                  data_out_valid,
  output logic                  frame_done
);

  localparam int unsigned LAST_IDX = MAP_SIZE - 1;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] out1_q, out1_d, out2_q, out2_d, out3_q, out3_d;
  logic                  valid_q, valid_d, done_q, done_d;
  logic                  beat_c, last_c, we1_c, we2_c, fire_c;
  logic [DATA_WIDTH-1:0] rd1_c, rd2_c;

  // Clear wins over a coincident data beat.
  assign beat_c = data_in_valid && !predict_end;
  assign last_c = (cnt_q == CNT_WIDTH'(LAST_IDX));

  reshape_split_channel_buffer #(
    .DATA_WIDTH(DATA_WIDTH), .MAP_SIZE(MAP_SIZE), .CNT_WIDTH(CNT_WIDTH)
  ) buf1 (
    .clk(clk), .we_i(we1_c), .waddr_i(cnt_q), .wdata_i(data_in),
    .raddr_i(cnt_q), .rdata_c(rd1_c)
  );

  reshape_split_channel_buffer #(
    .DATA_WIDTH(DATA_WIDTH), .MAP_SIZE(MAP_SIZE), .CNT_WIDTH(CNT_WIDTH)
  ) buf2 (
    .clk(clk), .we_i(we2_c), .waddr_i(cnt_q), .wdata_i(data_in),
    .raddr_i(cnt_q), .rdata_c(rd2_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CH1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: cnt walks one channel, wraps on its last beat and advances.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (predict_end) begin
      state_d = S_CH1;
      cnt_d   = '0;
    end else if (data_in_valid) begin
      if (last_c) begin
        cnt_d = '0;
        case (state_q)
          S_CH1:   state_d = S_CH2;
          S_CH2:   state_d = S_CH3;
          default: state_d = S_CH1;
        endcase
      end else begin
        cnt_d = CNT_WIDTH'(cnt_q + 1'b1);
      end
    end
  end

  always_comb begin
    we1_c   = 1'b0;
    we2_c   = 1'b0;
    fire_c  = 1'b0;
    case (state_q)
      S_CH1:   we1_c  = beat_c;
      S_CH2:   we2_c  = beat_c;
      S_CH3:   fire_c = beat_c;
      default: ;
    endcase
    out1_d  = fire_c ? rd1_c   : out1_q;
    out2_d  = fire_c ? rd2_c   : out2_q;
    out3_d  = fire_c ? data_in : out3_q;
    valid_d = fire_c;
    done_d  = fire_c && last_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1_q  <= '0;
      out2_q  <= '0;
      out3_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      out1_q  <= out1_d;
      out2_q  <= out2_d;
      out3_q  <= out3_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign data_out_1     = out1_q;
  assign data_out_2     = out2_q;
  assign data_out_3     = out3_q;
  assign data_out_valid = valid_q;
  assign frame_done     = done_q;

endmodule

// File: tb/tb_reshape_split.sv
// Self-checking bench for reshape_split: frame-index reference model plus
// literal checks on captured triples.
module tb_reshape_split;

  localparam int M = 25;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        predict_end;
  logic [31:0] data_in;
  logic        data_in_valid;
  logic [31:0] data_out_1, data_out_2, data_out_3;
  logic        data_out_valid, frame_done;

  reshape_split dut (
    .clk(clk), .rst_n(rst_n), .predict_end(predict_end),
    .data_in(data_in), .data_in_valid(data_in_valid),
    .data_out_1(data_out_1), .data_out_2(data_out_2), .data_out_3(data_out_3),
    .data_out_valid(data_out_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: position of each accepted word within its 75-word frame.
  logic [31:0] w [3*M];
  int          widx = 0;
  logic [31:0] exp_d1 = '0, exp_d2 = '0, exp_d3 = '0;
  logic        exp_v = 1'b0, exp_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      widx = 0; exp_v = 1'b0; exp_done = 1'b0;
      exp_d1 = '0; exp_d2 = '0; exp_d3 = '0;
    end else begin
      exp_v = 1'b0; exp_done = 1'b0;
      if (predict_end) begin
        widx = 0;
      end else if (data_in_valid) begin
        w[widx] = data_in;
        if (widx >= 2*M) begin
          exp_d1   = w[widx-2*M];
          exp_d2   = w[widx-M];
          exp_d3   = data_in;
          exp_v    = 1'b1;
          exp_done = (widx == 3*M-1);
        end
        widx = (widx == 3*M-1) ? 0 : widx + 1;
      end
    end
  end

  typedef struct {
    int          cyc;
    logic [31:0] d1, d2, d3;
    logic        done;
  } cap_t;
  cap_t cap[$];

  // Cycle-by-cycle comparison against the model, plus capture of triples.
  always @(negedge clk) begin
    chk("valid", 32'(data_out_valid), 32'(exp_v));
    chk("frame_done", 32'(frame_done), 32'(exp_done));
    chk("out1", data_out_1, exp_d1);
    chk("out2", data_out_2, exp_d2);
    chk("out3", data_out_3, exp_d3);
    if (data_out_valid) cap.push_back('{cyc, data_out_1, data_out_2, data_out_3, frame_done});
  end

  task automatic beat(input logic v, input logic [31:0] d, input logic pe);
    data_in = d; data_in_valid = v; predict_end = pe;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) beat(1'b0, $urandom, 1'b0);
  endtask

  task automatic send_frame(input int base);
    for (int i = 0; i < 3*M; i++) beat(1'b1, 32'(base + i), 1'b0);
  endtask

  // Hand-derived expectations: triple k is (base+k, base+M+k, base+2M+k).
  task automatic verify_frame(input int first, input int base, input int c0,
                              input int fc, input int step);
    if (cap.size() < first + M) begin
      n_cmp++; n_err++;
      $display("FAIL capture_count: got %0d, expected at least %0d", cap.size(), first + M);
    end else begin
      for (int k = 0; k < M; k++) begin
        chk("lit_d1", cap[first+k].d1, 32'(base + k));
        chk("lit_d2", cap[first+k].d2, 32'(base + M + k));
        chk("lit_d3", cap[first+k].d3, 32'(base + 2*M + k));
        chk("lit_cycle", 32'(cap[first+k].cyc - c0), 32'(fc + k*step));
        chk("lit_done", 32'(cap[first+k].done), 32'(k == M-1));
      end
    end
  endtask

  int c0;

  initial begin
    rst_n = 1'b0; predict_end = 1'b0; data_in = '0; data_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(data_out_valid), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_out1", data_out_1, 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Contiguous frame.
    cap.delete(); c0 = cyc;
    send_frame(1); idle(3);
    chk("contig_count", 32'(cap.size()), 32'(M));
    verify_frame(0, 1, c0, 51, 1);

    // Gapped frame: valid toggles 1,0,1,0.
    cap.delete(); c0 = cyc;
    for (int i = 0; i < 6*M; i++) begin
      if (i % 2 == 0) beat(1'b1, 32'(i/2 + 1), 1'b0);
      else            beat(1'b0, $urandom, 1'b0);
    end
    idle(3);
    chk("gap_count", 32'(cap.size()), 32'(M));
    verify_frame(0, 1, c0, 101, 2);

    // Back-to-back frames.
    cap.delete(); c0 = cyc;
    send_frame(1); send_frame(101); idle(3);
    chk("b2b_count", 32'(cap.size()), 32'(2*M));
    verify_frame(0, 1, c0, 51, 1);
    verify_frame(M, 101, c0, 126, 1);

    // Abort during ch2, then a clean frame.
    cap.delete();
    for (int i = 0; i < 40; i++) beat(1'b1, 32'(i + 1), 1'b0);
    beat(1'b0, '0, 1'b1);
    chk("abort_count", 32'(cap.size()), 32'd0);
    c0 = cyc;
    send_frame(1); idle(3);
    chk("abort_then_count", 32'(cap.size()), 32'(M));
    verify_frame(0, 1, c0, 51, 1);

    // Clear coincident with a ch3 beat drops that beat.
    cap.delete();
    for (int i = 0; i < 55; i++) beat(1'b1, 32'(i + 1), 1'b0);
    beat(1'b1, 32'd999, 1'b1);
    chk("pe_drop_valid", 32'(data_out_valid), 32'd0);
    chk("pe_drop_count", 32'(cap.size()), 32'd5);
    c0 = cyc;
    send_frame(1); idle(3);
    verify_frame(5, 1, c0, 51, 1);

    // Async reset mid-frame.
    for (int i = 0; i < 60; i++) beat(1'b1, 32'(i + 1), 1'b0);
    data_in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(data_out_valid), 32'd0);
    chk("arst_out1", data_out_1, 32'd0);
    chk("arst_out3", data_out_3, 32'd0);
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    cap.delete(); c0 = cyc;
    send_frame(1); idle(3);
    chk("arst_then_count", 32'(cap.size()), 32'(M));
    verify_frame(0, 1, c0, 51, 1);

    // Randomized traffic with gaps and occasional clears.
    for (int i = 0; i < 1200; i++)
      beat($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 249) == 0);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
